// File: rtl/atm_session_ctrl_pkg.sv
// Shared types and constants for the ATM session controller.
// Holds the session state encoding, op/result codes and default widths.
package atm_pkg;

    localparam int ACCT_W_D    = 4;
    localparam int AMT_W_D     = 10;
    localparam int PIN_W_D     = 16;
    localparam int MAX_TRIES_D = 3;
    localparam int RSP_TMO_D   = 255;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PIN,
        WAIT_OP,
        ISSUE,
        WAIT_RSP,
        EJECT
    } state_t;

    localparam logic [1:0] OP_EXIT = 2'b00;
    localparam logic [1:0] OP_INV  = 2'b01;
    localparam logic [1:0] OP_WDR  = 2'b10;
    localparam logic [1:0] OP_DEP  = 2'b11;

    localparam logic [1:0] RES_OK   = 2'b00;
    localparam logic [1:0] RES_REJ  = 2'b01;
    localparam logic [1:0] RES_LOCK = 2'b10;
    localparam logic [1:0] RES_TMO  = 2'b11;

endpackage

// File: rtl/atm_session_ctrl_if.sv
// Command/response link between the session controller and the transaction core.
// Command is a valid/ready handshake; the response is a one-cycle valid pulse.
interface atm_session_ctrl_if #(
    parameter int ACCT_W = 4,
    parameter int AMT_W  = 10
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_select;
    logic [ACCT_W-1:0] cmd_origin;
    logic [ACCT_W-1:0] cmd_purpose;
    logic [AMT_W-1:0]  cmd_amount;
    logic              rsp_valid;
    logic [1:0]        rsp_result;

    modport master (
        output cmd_valid, cmd_select, cmd_origin, cmd_purpose, cmd_amount,
        input  cmd_ready, rsp_valid, rsp_result
    );

    modport slave (
        input  cmd_valid, cmd_select, cmd_origin, cmd_purpose, cmd_amount,
        output cmd_ready, rsp_valid, rsp_result
    );
endinterface

// File: rtl/atm_session_ctrl_lock_table.sv
// Per-account saturating wrong-PIN counters plus a sticky lock bitmap.
// Updates land one cycle after inc/clr/lock; is_locked and cnt are combinational reads.
module atm_lock_table #(
    parameter int ACCT_W    = 4,
    parameter int MAX_TRIES = 3,
    parameter int CNT_W     = $clog2(MAX_TRIES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ACCT_W-1:0] rd_acct,
    output logic              is_locked,
    input  logic [ACCT_W-1:0] upd_acct,
    input  logic              inc,
    input  logic              clr,
    input  logic              lock,
    output logic [CNT_W-1:0]  cnt
);
    localparam int N = 1 << ACCT_W;

    logic [N-1:0]     lock_q;
    logic [CNT_W-1:0] cnt_q [N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q <= '0;
            for (int i = 0; i < N; i++) cnt_q[i] <= '0;
        end else begin
            if (clr)
                cnt_q[upd_acct] <= '0;
            else if (inc && cnt_q[upd_acct] != CNT_W'(MAX_TRIES))
                cnt_q[upd_acct] <= cnt_q[upd_acct] + 1'b1;
            // Lock bits are sticky until reset.
            if (lock)
                lock_q[upd_acct] <= 1'b1;
        end
    end

    assign is_locked = lock_q[rd_acct];
    assign cnt       = cnt_q[upd_acct];

endmodule

// File: rtl/atm_session_ctrl.sv
// Card session FSM: PIN check with lockout, one op per card, command/response to the core, eject.
// Optional ATM_INACT_TMO_EN adds a 50000-cycle inactivity eject in WAIT_PIN/WAIT_OP.
module atm_session_ctrl
    import atm_pkg::*;
#(
    parameter int ACCT_W    = ACCT_W_D,
    parameter int AMT_W     = AMT_W_D,
    parameter int PIN_W     = PIN_W_D,
    parameter int MAX_TRIES = MAX_TRIES_D,
    parameter int RSP_TMO   = RSP_TMO_D
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                card_valid,
    input  logic [ACCT_W-1:0]   card_acct,
    input  logic                pin_valid,
    input  logic [PIN_W-1:0]    pin_val,
    input  logic [PIN_W-1:0]    pin_ref,
    output logic [ACCT_W-1:0]   sess_acct,
    input  logic                op_valid,
    input  logic [1:0]          op_sel,
    input  logic [ACCT_W-1:0]   op_dest,
    input  logic [AMT_W-1:0]    op_amount,
    atm_session_ctrl_if.master  core,
    output logic                card_eject,
    output logic [1:0]          sess_result,
    output logic                locked
);
    localparam int CNT_W = $clog2(MAX_TRIES + 1);
    localparam int TMR_W = $clog2(RSP_TMO + 1);

    state_t            state_q, state_d;
    logic [ACCT_W-1:0] acct_q, acct_d;
    logic [1:0]        res_q, res_d;
    logic              locked_q, locked_d;
    logic              eject_q, eject_d;
    logic              cvld_q, cvld_d;
    logic [1:0]        csel_q, csel_d;
    logic [ACCT_W-1:0] cpur_q, cpur_d;
    logic [AMT_W-1:0]  camt_q, camt_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;

    logic              lt_locked, lt_inc, lt_clr, lt_lock;
    logic [CNT_W-1:0]  lt_cnt;
    logic [CNT_W:0]    cnt_nxt;
    logic              will_lock, op_rej, inact_hit;

    atm_lock_table #(.ACCT_W(ACCT_W), .MAX_TRIES(MAX_TRIES)) u_lock (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_acct   (card_acct),
        .is_locked (lt_locked),
        .upd_acct  (acct_q),
        .inc       (lt_inc),
        .clr       (lt_clr),
        .lock      (lt_lock),
        .cnt       (lt_cnt)
    );

    assign cnt_nxt   = {1'b0, lt_cnt} + 1'b1;
    assign will_lock = cnt_nxt >= (CNT_W + 1)'(MAX_TRIES);
    assign op_rej    = (op_sel == OP_DEP && op_dest == acct_q) ||
                       (op_sel != OP_EXIT && op_sel != OP_INV && op_amount == '0);

`ifdef ATM_INACT_TMO_EN
    localparam logic [15:0] INACT_TMO = 16'd50000;
    logic [15:0] inact_q;
    logic        waiting;

    assign waiting = (state_q == WAIT_PIN) || (state_q == WAIT_OP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            inact_q <= '0;
        else if (!waiting || pin_valid || op_valid)
            inact_q <= '0;
        else
            inact_q <= inact_q + 1'b1;
    end

    // Fires on the 50000th consecutive quiet cycle.
    assign inact_hit = waiting && (inact_q == INACT_TMO - 16'd1);
`else
    assign inact_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        acct_d   = acct_q;
        res_d    = res_q;
        locked_d = locked_q;
        eject_d  = 1'b0;
        cvld_d   = cvld_q;
        csel_d   = csel_q;
        cpur_d   = cpur_q;
        camt_d   = camt_q;
        tmr_d    = tmr_q;
        lt_inc   = 1'b0;
        lt_clr   = 1'b0;
        lt_lock  = 1'b0;
        case (state_q)
            IDLE: if (card_valid) begin
                acct_d = card_acct;
                if (lt_locked) begin
                    state_d  = EJECT;
                    res_d    = RES_LOCK;
                    locked_d = 1'b1;
                    eject_d  = 1'b1;
                end else begin
                    state_d = WAIT_PIN;
                end
            end
            WAIT_PIN: if (pin_valid) begin
                if (pin_val == pin_ref) begin
                    lt_clr  = 1'b1;
                    state_d = WAIT_OP;
                end else begin
                    lt_inc = 1'b1;
                    if (will_lock) begin
                        lt_lock  = 1'b1;
                        res_d    = RES_LOCK;
                        locked_d = 1'b1;
                        eject_d  = 1'b1;
                        state_d  = EJECT;
                    end
                end
            end else if (inact_hit) begin
                res_d   = RES_TMO;
                eject_d = 1'b1;
                state_d = EJECT;
            end
            WAIT_OP: if (op_valid) begin
                if (op_sel == OP_EXIT) begin
                    res_d   = RES_OK;
                    eject_d = 1'b1;
                    state_d = EJECT;
                end else if (op_rej) begin
                    res_d = RES_REJ;
                end else begin
                    csel_d  = op_sel;
                    cpur_d  = op_dest;
                    camt_d  = op_amount;
                    cvld_d  = 1'b1;
                    state_d = ISSUE;
                end
            end else if (inact_hit) begin
                res_d   = RES_TMO;
                eject_d = 1'b1;
                state_d = EJECT;
            end
            ISSUE: if (core.cmd_ready) begin
                cvld_d  = 1'b0;
                tmr_d   = '0;
                state_d = WAIT_RSP;
            end
            // A response in the timeout cycle takes priority over the timeout.
            WAIT_RSP: if (core.rsp_valid) begin
                res_d   = core.rsp_result;
                eject_d = 1'b1;
                state_d = EJECT;
            end else if (tmr_q == TMR_W'(RSP_TMO)) begin
                res_d   = RES_TMO;
                eject_d = 1'b1;
                state_d = EJECT;
            end else begin
                tmr_d = tmr_q + 1'b1;
            end
            EJECT: begin
                locked_d = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acct_q   <= '0;
            res_q    <= '0;
            locked_q <= 1'b0;
            eject_q  <= 1'b0;
            cvld_q   <= 1'b0;
            csel_q   <= '0;
            cpur_q   <= '0;
            camt_q   <= '0;
            tmr_q    <= '0;
        end else begin
            state_q  <= state_d;
            acct_q   <= acct_d;
            res_q    <= res_d;
            locked_q <= locked_d;
            eject_q  <= eject_d;
            cvld_q   <= cvld_d;
            csel_q   <= csel_d;
            cpur_q   <= cpur_d;
            camt_q   <= camt_d;
            tmr_q    <= tmr_d;
        end
    end

    assign sess_acct        = acct_q;
    assign sess_result      = res_q;
    assign locked           = locked_q;
    assign card_eject       = eject_q;
    assign core.cmd_valid   = cvld_q;
    assign core.cmd_select  = csel_q;
    assign core.cmd_origin  = acct_q;
    assign core.cmd_purpose = cpur_q;
    assign core.cmd_amount  = camt_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Session-level bench: a table of card sessions plus hand-written reject and reset sequences.
// Issued commands are predicted into a queue and compared when the core accepts them.
module tb_atm_session_ctrl;
    localparam int RSP_TMO = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        card_valid = 1'b0;
    logic [3:0]  card_acct = '0;
    logic        pin_valid = 1'b0;
    logic [15:0] pin_val = '0;
    logic [15:0] pin_ref;
    logic [3:0]  sess_acct;
    logic        op_valid = 1'b0;
    logic [1:0]  op_sel = '0;
    logic [3:0]  op_dest = '0;
    logic [9:0]  op_amount = '0;
    logic        card_eject;
    logic [1:0]  sess_result;
    logic        locked;

    atm_session_ctrl_if cif();

    atm_session_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .card_valid  (card_valid),
        .card_acct   (card_acct),
        .pin_valid   (pin_valid),
        .pin_val     (pin_val),
        .pin_ref     (pin_ref),
        .sess_acct   (sess_acct),
        .op_valid    (op_valid),
        .op_sel      (op_sel),
        .op_dest     (op_dest),
        .op_amount   (op_amount),
        .core        (cif),
        .card_eject  (card_eject),
        .sess_result (sess_result),
        .locked      (locked)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] good_pin(input logic [3:0] a);
        return {12'h4A7, a};
    endfunction

    assign pin_ref = good_pin(sess_acct);

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] org;
        logic [3:0] pur;
        logic [9:0] amt;
    } cmd_t;

    cmd_t exp_q[$];
    cmd_t cur_c, prev_c;
    logic prev_wait = 1'b0;

    assign cur_c = {cif.cmd_select, cif.cmd_origin, cif.cmd_purpose, cif.cmd_amount};

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_wait <= 1'b0;
        end else begin
            if (prev_wait) begin
                check("cmd_valid_hold", 32'(cif.cmd_valid), 32'd1);
                check("cmd_stable", 32'(cur_c), 32'(prev_c));
            end
            if (cif.cmd_valid && cif.cmd_ready) begin
                if (exp_q.size() == 0) check("cmd_unexpected", 32'(exp_q.size()), 32'd1);
                else check("cmd_accept", 32'(cur_c), 32'(exp_q.pop_front()));
            end
            prev_wait <= cif.cmd_valid && !cif.cmd_ready;
            prev_c    <= cur_c;
        end
    end

    typedef struct {
        logic [3:0] acct;
        int         n_bad;
        bit         good;
        logic [1:0] sel;
        logic [3:0] dest;
        logic [9:0] amt;
        int         rdy_dly;
        bit         send;
        logic [1:0] rsp;
        bit         x_early;
        bit         x_pinlock;
        bit         x_rej;
        bit         x_cmd;
        logic [1:0] x_res;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [1:0] s, input logic [3:0] d, input logic [9:0] a);
        op_valid = 1'b1; op_sel = s; op_dest = d; op_amount = a;
        tick();
        op_valid = 1'b0;
    endtask

    task automatic finish_eject(input string tag, input logic [3:0] acct,
                                input logic [1:0] res, input logic lk);
        check($sformatf("%s_eject", tag), 32'(card_eject), 32'd1);
        check($sformatf("%s_result", tag), 32'(sess_result), 32'(res));
        check($sformatf("%s_locked", tag), 32'(locked), 32'(lk));
        check($sformatf("%s_acct_hold", tag), 32'(sess_acct), 32'(acct));
        tick();
        check($sformatf("%s_eject_pulse", tag), 32'(card_eject), 32'd0);
    endtask

    task automatic serve(input string tag, input int rdy_dly, input bit send, input logic [1:0] rsp);
        int n;
        n = 0;
        while (!cif.cmd_valid && n < 4) begin tick(); n++; end
        check($sformatf("%s_cmd_valid", tag), 32'(cif.cmd_valid), 32'd1);
        repeat (rdy_dly) tick();
        cif.cmd_ready = 1'b1;
        tick();
        cif.cmd_ready = 1'b0;
        if (send) begin
            cif.rsp_valid = 1'b1; cif.rsp_result = rsp;
            tick();
            cif.rsp_valid = 1'b0;
        end else begin
            n = 0;
            while (!card_eject && n < RSP_TMO + 20) begin tick(); n++; end
            check($sformatf("%s_tmo_cycles", tag), 32'(n), 32'(RSP_TMO + 1));
        end
    endtask

    task automatic run(input vec_t v, input string tag);
        card_valid = 1'b1; card_acct = v.acct;
        tick();
        card_valid = 1'b0;
        check($sformatf("%s_sess_acct", tag), 32'(sess_acct), 32'(v.acct));
        if (v.x_early) begin
            finish_eject(tag, v.acct, v.x_res, 1'b1);
            return;
        end
        check($sformatf("%s_open", tag), 32'({card_eject, locked}), 32'd0);
        for (int i = 0; i < v.n_bad; i++) begin
            pin_valid = 1'b1; pin_val = ~good_pin(v.acct);
            tick();
            pin_valid = 1'b0;
            if (i < v.n_bad - 1 || !v.x_pinlock)
                check($sformatf("%s_bad_pin%0d", tag, i), 32'(card_eject), 32'd0);
        end
        if (v.x_pinlock) begin
            finish_eject(tag, v.acct, v.x_res, 1'b1);
            return;
        end
        pin_valid = 1'b1; pin_val = good_pin(v.acct);
        tick();
        pin_valid = 1'b0;
        check($sformatf("%s_pin_ok", tag), 32'(card_eject), 32'd0);
        if (v.x_cmd) exp_q.push_back({v.sel, v.acct, v.dest, v.amt});
        do_op(v.sel, v.dest, v.amt);
        if (v.x_rej) begin
            check($sformatf("%s_rej_result", tag), 32'(sess_result), 32'd1);
            check($sformatf("%s_rej_nocmd", tag), 32'({cif.cmd_valid, card_eject}), 32'd0);
            do_op(2'b00, 4'd0, 10'd0);
        end else if (v.x_cmd) begin
            serve(tag, v.rdy_dly, v.send, v.rsp);
        end
        finish_eject(tag, v.acct, v.x_res, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[9];
        vec_t post;
        cif.cmd_ready  = 1'b0;
        cif.rsp_valid  = 1'b0;
        cif.rsp_result = 2'b00;

        vt[0] = '{4'd5,  0, 1'b1, 2'b01, 4'd0, 10'd0,   0,  1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00};
        vt[1] = '{4'd3,  3, 1'b0, 2'b00, 4'd0, 10'd0,   0,  1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10};
        vt[2] = '{4'd3,  0, 1'b0, 2'b00, 4'd0, 10'd0,   0,  1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10};
        vt[3] = '{4'd7,  2, 1'b1, 2'b10, 4'd0, 10'd100, 2,  1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01};
        vt[4] = '{4'd7,  1, 1'b1, 2'b11, 4'd2, 10'd55,  0,  1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10};
        vt[5] = '{4'd9,  0, 1'b1, 2'b11, 4'd9, 10'd5,   0,  1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
        vt[6] = '{4'd9,  0, 1'b1, 2'b10, 4'd0, 10'd0,   0,  1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00};
        vt[7] = '{4'd2,  0, 1'b1, 2'b00, 4'd0, 10'd0,   0,  1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
        vt[8] = '{4'd12, 0, 1'b1, 2'b10, 4'd4, 10'd300, 20, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11};

        #2 rst_n = 1'b0;
        tick();
        tick();
        check("reset_outputs",
              32'({cif.cmd_valid, card_eject, sess_result, locked, sess_acct, cif.cmd_select}), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) run(vt[i], $sformatf("vec%0d", i));

        // Rejected deposit followed by a valid withdraw in the same session.
        card_valid = 1'b1; card_acct = 4'd6;
        tick();
        card_valid = 1'b0;
        pin_valid = 1'b1; pin_val = good_pin(4'd6);
        tick();
        pin_valid = 1'b0;
        do_op(2'b11, 4'd6, 10'd10);
        check("rej_then_cmd_result", 32'(sess_result), 32'd1);
        check("rej_then_cmd_novalid", 32'(cif.cmd_valid), 32'd0);
        exp_q.push_back({2'b10, 4'd6, 4'd1, 10'd100});
        do_op(2'b10, 4'd1, 10'd100);
        serve("rej_then_cmd", 0, 1'b1, 2'b00);
        finish_eject("rej_then_cmd", 4'd6, 2'b00, 1'b0);

        // Reset while waiting for the core response.
        card_valid = 1'b1; card_acct = 4'd4;
        tick();
        card_valid = 1'b0;
        pin_valid = 1'b1; pin_val = good_pin(4'd4);
        tick();
        pin_valid = 1'b0;
        exp_q.push_back({2'b10, 4'd4, 4'd1, 10'd33});
        do_op(2'b10, 4'd1, 10'd33);
        cif.cmd_ready = 1'b1;
        tick();
        cif.cmd_ready = 1'b0;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_outputs",
              32'({cif.cmd_valid, card_eject, sess_result, locked, sess_acct,
                   cif.cmd_select, cif.cmd_origin, cif.cmd_purpose}), 32'd0);
        check("rst_async_amount", 32'(cif.cmd_amount), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rst_no_eject%0d", i), 32'(card_eject), 32'd0);
        end
        rst_n = 1'b1;
        tick();

        // Account 3 was locked before reset; the bitmap must now be clear.
        post = '{4'd3, 0, 1'b1, 2'b00, 4'd0, 10'd0, 0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
        run(post, "post_rst");

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
